// File: rtl/rsa_pkg.sv
// Shared RSA/MMM definitions: result-unloader FSM states and the default
// host-side chunk width, which the SPI output formatter also uses.
package rsa_pkg;

  localparam int UNLOAD_CHUNK = 4;

  typedef enum logic {
    UNLOAD_IDLE,
    UNLOAD_SEND
  } unload_state_t;

endpackage

// File: rtl/mmm_result_unloader.sv
// Captures a finished Montgomery product in one cycle and streams it out
// MSB chunk first over valid/ready, freeing the datapath for the next operation.
module mmm_result_unloader
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = UNLOAD_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] R_i,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("mmm_result_unloader: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  unload_state_t    state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc  = cnt + 1'b1;
  assign out_data = shreg[WIDTH-1 -: CHUNK];

  // out_last is precomputed one chunk ahead so it never depends on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UNLOAD_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        UNLOAD_IDLE: begin
          if (start && en && !abort) begin
            state     <= UNLOAD_SEND;
            shreg     <= R_i;
            cnt       <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_last  <= (NCHUNK == 1);
          end
        end
        UNLOAD_SEND: begin
          if (abort) begin
            state     <= UNLOAD_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (out_ready) begin
            if (out_last) begin
              state     <= UNLOAD_IDLE;
              shreg     <= '0;
              cnt       <= '0;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              shreg    <= shreg << CHUNK;
              cnt      <= cnt_inc;
              out_last <= (cnt_inc == LAST_CNT);
            end
          end
        end
        default: state <= UNLOAD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_result_unloader.sv
// Self-checking bench: directed tables and sequences plus randomized traffic
// compared against a queue-of-chunks reference model.
module tb_mmm_result_unloader;

  logic clk = 1'b0;
  logic rst, en, start, abort, out_ready;
  logic [7:0]  r8;
  logic [15:0] r16;
  logic        b8, v8, l8, dn8;
  logic [3:0]  d8;
  logic        b16, v16, l16, dn16;
  logic [3:0]  d16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmm_result_unloader #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort), .R_i(r8),
    .busy(b8), .out_valid(v8), .out_ready(out_ready), .out_data(d8),
    .out_last(l8), .done(dn8)
  );

  mmm_result_unloader #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort), .R_i(r16),
    .busy(b16), .out_valid(v16), .out_ready(out_ready), .out_data(d16),
    .out_last(l16), .done(dn16)
  );

  // Reference for the 16-bit instance: the chunks still owed to the sink.
  logic [3:0] mq[$];
  bit         mdone = 0;

  always @(posedge clk) begin
    mdone = 0;
    if (rst) begin
      mq.delete();
    end else if (mq.size() > 0) begin
      if (abort) begin
        mq.delete();
      end else if (out_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) mdone = 1;
      end
    end else if (start && en && !abort) begin
      for (int i = 3; i >= 0; i--) mq.push_back(r16[i*4 +: 4]);
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("model_busy", 16'(b16), 16'(mq.size() > 0));
    checkOutput("model_valid", 16'(v16), 16'(mq.size() > 0));
    checkOutput("model_last", 16'(l16), 16'(mq.size() == 1));
    checkOutput("model_done", 16'(dn16), 16'(mdone));
    if (mq.size() > 0) checkOutput("model_data", 16'(d16), 16'(mq[0]));
  endtask

  task automatic applyStimulus(input bit s, input bit e, input bit a, input bit r,
                               input logic [15:0] rv);
    start = s; en = e; abort = a; out_ready = r; r16 = rv; r8 = rv[7:0];
    @(posedge clk);
    #1;
    checkModel();
  endtask

  typedef struct {
    bit         start;
    bit         ready;
    bit         ev;
    logic [3:0] ed;
    bit         el;
    bit         edone;
  } bp_vec_t;

  bp_vec_t bp[9];
  int      doneCount;
  logic [3:0] got[$];

  initial begin
    bp[0] = '{1, 0, 1, 4'h1, 0, 0};
    bp[1] = '{0, 1, 1, 4'h2, 0, 0};
    bp[2] = '{0, 0, 1, 4'h2, 0, 0};
    bp[3] = '{0, 0, 1, 4'h2, 0, 0};
    bp[4] = '{0, 1, 1, 4'h3, 0, 0};
    bp[5] = '{0, 0, 1, 4'h3, 0, 0};
    bp[6] = '{0, 1, 1, 4'h4, 1, 0};
    bp[7] = '{0, 1, 0, 4'h0, 0, 1};
    bp[8] = '{0, 1, 0, 4'h0, 0, 0};

    rst = 1; en = 0; start = 0; abort = 0; out_ready = 0; r8 = '0; r16 = '0;
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 16'h0);
    $display("[TB] reset values");
    checkOutput("rst_busy8", 16'(b8), 0);
    checkOutput("rst_valid8", 16'(v8), 0);
    checkOutput("rst_data8", 16'(d8), 0);
    checkOutput("rst_last8", 16'(l8), 0);
    checkOutput("rst_done8", 16'(dn8), 0);
    checkOutput("rst_data16", 16'(d16), 0);
    rst = 0;

    $display("[TB] basic unload 8'hA5");
    applyStimulus(1, 1, 0, 1, 16'h00A5);
    checkOutput("basic_v0", 16'(v8), 1);
    checkOutput("basic_d0", 16'(d8), 16'hA);
    checkOutput("basic_l0", 16'(l8), 0);
    checkOutput("basic_b0", 16'(b8), 1);
    applyStimulus(0, 1, 0, 1, 16'h0);
    checkOutput("basic_d1", 16'(d8), 16'h5);
    checkOutput("basic_l1", 16'(l8), 1);
    checkOutput("basic_done_early", 16'(dn8), 0);
    applyStimulus(0, 1, 0, 1, 16'h0);
    checkOutput("basic_done", 16'(dn8), 1);
    checkOutput("basic_v_end", 16'(v8), 0);
    checkOutput("basic_b_end", 16'(b8), 0);
    applyStimulus(0, 1, 0, 1, 16'h0);
    checkOutput("basic_done_pulse", 16'(dn8), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 16'h0);

    $display("[TB] back-pressure table 16'h1234");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(bp[i].start, 1, 0, bp[i].ready, (i == 0) ? 16'h1234 : 16'h0);
      checkOutput($sformatf("bp_valid_%0d", i), 16'(v16), 16'(bp[i].ev));
      checkOutput($sformatf("bp_last_%0d", i), 16'(l16), 16'(bp[i].el));
      checkOutput($sformatf("bp_done_%0d", i), 16'(dn16), 16'(bp[i].edone));
      if (bp[i].ev) checkOutput($sformatf("bp_data_%0d", i), 16'(d16), 16'(bp[i].ed));
    end

    $display("[TB] ignored start mid-transfer");
    doneCount = 0;
    got.delete();
    applyStimulus(1, 1, 0, 1, 16'hCAFE);
    for (int i = 0; i < 8; i++) begin
      if (v16) got.push_back(d16);
      applyStimulus(i == 1, 1, 0, 1, 16'hFFFF);
      if (dn16) doneCount++;
    end
    checkOutput("ign_done_count", 16'(doneCount), 1);
    checkOutput("ign_chunks", {got.size() > 0 ? got[0] : 4'h0, got.size() > 1 ? got[1] : 4'h0,
                               got.size() > 2 ? got[2] : 4'h0, got.size() > 3 ? got[3] : 4'h0},
                16'hCAFE);
    checkOutput("ign_count", 16'(got.size()), 4);
    checkOutput("ign_idle", 16'(b16), 0);

    $display("[TB] abort then restart");
    applyStimulus(1, 1, 0, 0, 16'h1357);
    applyStimulus(0, 1, 0, 1, 16'h0);
    applyStimulus(0, 1, 1, 0, 16'h0);
    checkOutput("abort_busy", 16'(b16), 0);
    checkOutput("abort_valid", 16'(v16), 0);
    checkOutput("abort_done", 16'(dn16), 0);
    checkOutput("abort_data", 16'(d16), 0);
    applyStimulus(1, 1, 1, 1, 16'h2468);
    checkOutput("abort_blocks_start", 16'(b16), 0);
    got.delete();
    applyStimulus(1, 1, 0, 1, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      if (v16) got.push_back(d16);
      applyStimulus(0, 1, 0, 1, 16'h0);
    end
    checkOutput("restart_count", 16'(got.size()), 4);
    if (got.size() == 4) checkOutput("restart_chunks", {got[0], got[1], got[2], got[3]}, 16'hBEEF);

    $display("[TB] reset mid-transfer");
    applyStimulus(1, 1, 0, 1, 16'h5A5A);
    applyStimulus(0, 1, 0, 1, 16'h0);
    rst = 1;
    applyStimulus(0, 1, 0, 1, 16'h0);
    checkOutput("rstmid_busy", 16'(b16), 0);
    checkOutput("rstmid_valid", 16'(v16), 0);
    checkOutput("rstmid_data", 16'(d16), 0);
    checkOutput("rstmid_last", 16'(l16), 0);
    checkOutput("rstmid_done", 16'(dn16), 0);
    rst = 0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 16'h0);
    checkOutput("rstmid_quiet", 16'(v16), 0);

    $display("[TB] back-to-back and en gating");
    applyStimulus(1, 1, 0, 1, 16'h0F1E);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 16'h0);
    applyStimulus(0, 1, 0, 1, 16'h0);
    checkOutput("b2b_done", 16'(dn16), 1);
    applyStimulus(1, 1, 0, 1, 16'h7654);
    checkOutput("b2b_valid", 16'(v16), 1);
    checkOutput("b2b_data", 16'(d16), 16'h7);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 1, 16'h0);
    applyStimulus(1, 0, 0, 1, 16'h9999);
    checkOutput("gate_busy", 16'(b16), 0);
    checkOutput("gate_valid", 16'(v16), 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                    16'($urandom));
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmm_result_unloader.md
# mmm_result_unloader

Reads a completed Montgomery-multiplication result out of the `WIDTH`-bit result register and streams it to the host side as `CHUNK`-bit words over a valid/ready handshake, MSB chunk first. It is the read-side counterpart of the result register's parallel load path. It sits between the MMM datapath and the SPI/host output interface. It captures the result in one cycle, so the datapath is free to start the next operation while unloading continues.

## Interface
Parameters:
- `WIDTH`, default 8: result width in bits. Must be a multiple of `CHUNK`.
- `CHUNK`, default 4: output word width in bits.
- `NCHUNK`, derived: `WIDTH/CHUNK`. Not user-settable.

Ports:
- `clk`  input  1: single clock. All state is updated on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `en`  input  1: qualifies `start`. Has no effect on a transfer already in progress.
- `start`  input  1: one-cycle capture request. Sampled only when `en`=1 and in IDLE.
- `abort`  input  1: synchronous cancel of an in-progress unload.
- `R_i`  input  `WIDTH`: result register contents. Sampled only at capture.
- `busy`  output  1: high from the cycle after capture until the final handshake.
- `out_valid`  output  1: `out_data` holds a valid chunk.
- `out_ready`  input  1: the sink accepts the chunk.
- `out_data`  output  `CHUNK`: current chunk, MSB-first.
- `out_last`  output  1: the current chunk is chunk `NCHUNK-1`.
- `done`  output  1: one-cycle pulse after the last chunk is accepted.

## Operation
- FSM states are IDLE and SEND.
- IDLE → SEND when `start` & `en` & !`abort`. On that edge:
  - `shreg` ← `R_i`
  - `cnt` ← 0
- SEND:
  - `out_valid`=1.
  - `out_data` = `shreg[WIDTH-1 -: CHUNK]`.
  - `out_last` = (`cnt` == `NCHUNK-1`).
- A handshake is `out_valid` & `out_ready`. On a handshake that is not the last chunk:
  - `shreg` ← `shreg << CHUNK`, with zero fill.
  - `cnt` ← `cnt`+1.
- A handshake with `out_last`=1 returns the FSM to IDLE and sets `done`=1 for one cycle.
- `out_valid`, `out_data` and `out_last` are registered or decoded from registers only. None of them has a combinational path from `out_ready`.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- `start` while in SEND is ignored. It is not queued.
- `abort` in SEND returns to IDLE on the next edge. `done` is not pulsed, and `shreg` is cleared. `abort` in IDLE is a no-op and blocks a coincident `start`.
- `en`=0 during SEND does not stall or alter the transfer.
- The `cnt` width is `$clog2(NCHUNK)`, minimum 1. It never exceeds `NCHUNK-1`, so it never wraps.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `done`=0. The state is IDLE, `shreg`=0, `cnt`=0.
- `rst` takes priority over `abort`, `start` and handshakes, including in the middle of a transfer.
- With `start` high at edge N, `busy` and `out_valid` are high after edge N, and the first chunk is presented in cycle N+1.
- With `out_ready` held high, one chunk transfers per cycle. Capture to `done` is `NCHUNK`+1 cycles.
- `done` is high in the cycle after the last handshake, at the same time that `busy` and `out_valid` fall.
- The earliest new `start` is accepted in the cycle where `done`=1, which makes it back-to-back with the previous unload.
- `R_i` may change at any time after the capture edge without affecting output.

## Structure
- The shared `rsa_pkg` holds:
  - the `unload_state_t` enum typedef (`UNLOAD_IDLE`, `UNLOAD_SEND`)
  - the default `CHUNK` localparam, shared with the SPI output formatter.
- Single module with no sub-modules. The shift register, counter and FSM are all inline.
- An elaboration-time assertion checks `WIDTH % CHUNK == 0` and `CHUNK <= WIDTH`.

## Test plan
- **Basic unload.** `WIDTH`=8, `CHUNK`=4, `R_i`=8'hA5, `start` pulse, `out_ready`=1 → chunks 4'hA then 4'h5. `out_last` is high only on 4'h5. `done` pulses 3 cycles after the capture edge.
- **Back-pressure.** `WIDTH`=16, `R_i`=16'h1234, `out_ready` toggling 1,0,0,1,0,1,1 → the sink receives exactly 1,2,3,4. `out_data` is stable during each stall.
- **Ignored start.** `start` pulsed mid-SEND with `R_i` changed to 16'hFFFF → the original chunks complete unchanged, with no second unload and a single `done` pulse.
- **Abort.** `abort` after the first chunk → IDLE on the next edge, with `busy`=0, `out_valid`=0 and no `done`. A following `start` with `R_i`=16'hBEEF yields B, E, E, F.
- **Reset mid-transfer.** `rst` asserted during SEND → all outputs are 0 on the next edge. After `rst` releases, no output appears until a new `start`.
- **Back-to-back and gating.** `start` in the `done` cycle yields back-to-back unloads. `start` with `en`=0 in IDLE is ignored, and `busy` stays 0.
